param_mac: RTL and testbench

Parametrised multiply-accumulate unit computing a biased dot product f = x + sum(a_i*b_i) over a vector of VEC_LEN element pairs. It generalises data/accumulator width, vector length and multiplier depth, and adds valid/ready backpressure, a selectable saturate-or-wrap mode and a synchronous flush. It sits between the weight/activation feeders and the activation stage of the neural datapath.

---
 rtl/param_mac_if.sv | 27 ++
 rtl/param_mac.sv | 129 ++++++++++++
 tb/tb_param_mac.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_mac_if.sv
// Element/result handshake bundle for param_mac: operand feed on one side,
// accumulated result with backpressure on the other.
interface param_mac_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic        [DATA_W-1:0] x;
    logic                     valid_in;
    logic                     in_ready;
    logic                     flush;
    logic signed [ACC_W-1:0]  f;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overflow;

    modport master (
        output a, b, x, valid_in, flush, out_ready,
        input  in_ready, f, out_valid, overflow
    );

    modport slave (
        input  a, b, x, valid_in, flush, out_ready,
        output in_ready, f, out_valid, overflow
    );
endinterface

// File: rtl/param_mac.sv
// Pipelined biased dot-product MAC: f = x + sum(a_i*b_i) over VEC_LEN pairs,
// with stall-on-backpressure, synchronous flush and optional saturation.
module param_mac #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int VEC_LEN     = 3,
    parameter int MULT_STAGES = 1,
    parameter int SAT_EN      = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    param_mac_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] op_a,
                                     input logic signed [ACC_W-1:0] op_b,
                                     input logic signed [ACC_W-1:0] sum);
        return (op_a[ACC_W-1] == op_b[ACC_W-1]) && (sum[ACC_W-1] != op_a[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] sum,
                                                         input logic ovf,
                                                         input logic neg);
        if ((SAT_EN != 0) && ovf)
            return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum;
    endfunction

    logic [CNT_W-1:0] elem_cnt;
    logic             ready_q;
    logic             stall;
    logic             accept;

    logic signed [DATA_W-1:0] a_p0, b_p0;
    logic        [DATA_W-1:0] x_p0;
    logic                     vld_p0, first_p0, last_p0;

    logic signed [PROD_W-1:0] prod_p1 [MULT_STAGES];
    logic        [DATA_W-1:0] x_p1    [MULT_STAGES];
    logic [MULT_STAGES-1:0]   vld_p1, first_p1, last_p1;

    logic signed [ACC_W-1:0]  prod_p2;
    logic        [DATA_W-1:0] x_p2;
    logic                     vld_p2, first_p2, last_p2;

    logic signed [ACC_W-1:0]  acc_base, acc_sum, acc_next;
    logic                     ovf_now;

    // A held result freezes the whole pipeline, so nothing new may enter either.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ready_q & ~stall & ~bus.flush;
    assign accept       = bus.valid_in & bus.in_ready;

    always_comb begin
        acc_base = first_p2 ? $signed(ACC_W'(x_p2)) : bus.f;
        acc_sum  = acc_base + prod_p2;
        ovf_now  = add_ovf(acc_base, prod_p2, acc_sum);
        acc_next = saturate(acc_sum, ovf_now, acc_base[ACC_W-1]);
    end

    // Control and architecturally visible state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q       <= 1'b0;
            elem_cnt      <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= '0;
            vld_p2        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.f         <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (bus.flush) begin
                elem_cnt      <= '0;
                vld_p0        <= 1'b0;
                vld_p1        <= '0;
                vld_p2        <= 1'b0;
                bus.out_valid <= 1'b0;
            end else if (!stall) begin
                if (accept)
                    elem_cnt <= (elem_cnt == CNT_W'(VEC_LEN-1)) ? '0 : elem_cnt + CNT_W'(1);
                vld_p0    <= accept;
                vld_p1[0] <= vld_p0;
                for (int k = 1; k < MULT_STAGES; k++)
                    vld_p1[k] <= vld_p1[k-1];
                vld_p2        <= vld_p1[MULT_STAGES-1];
                bus.out_valid <= vld_p2 & last_p2;
                if (vld_p2) begin
                    bus.f        <= acc_next;
                    bus.overflow <= first_p2 ? ovf_now : (bus.overflow | ovf_now);
                end
            end
        end
    end

    // Stage p0: input capture
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0     <= bus.a;
            b_p0     <= bus.b;
            x_p0     <= bus.x;
            first_p0 <= (elem_cnt == '0);
            last_p0  <= (elem_cnt == CNT_W'(VEC_LEN-1));
        end
    end

    // Stage p1: multiplier register chain; stage p2: sign-extended product
    always_ff @(posedge clk) begin
        if (!stall) begin
            prod_p1[0]  <= PROD_W'(a_p0) * PROD_W'(b_p0);
            x_p1[0]     <= x_p0;
            first_p1[0] <= first_p0;
            last_p1[0]  <= last_p0;
            for (int k = 1; k < MULT_STAGES; k++) begin
                prod_p1[k]  <= prod_p1[k-1];
                x_p1[k]     <= x_p1[k-1];
                first_p1[k] <= first_p1[k-1];
                last_p1[k]  <= last_p1[k-1];
            end
            prod_p2  <= ACC_W'(prod_p1[MULT_STAGES-1]);
            x_p2     <= x_p1[MULT_STAGES-1];
            first_p2 <= first_p1[MULT_STAGES-1];
            last_p2  <= last_p1[MULT_STAGES-1];
        end
    end
endmodule

// File: tb/tb_param_mac.sv
// Scoreboard bench for param_mac: wrap and saturating instances share stimulus,
// expected results are queued at issue and popped on each output handshake.
module tb_param_mac;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef struct packed {
        logic [ACC_W-1:0] f;
        logic             ov;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q_wrap[$];
    exp_t q_sat[$];

    always #5 clk = ~clk;

    param_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus0 ();
    param_mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus1 ();

    assign bus1.a         = bus0.a;
    assign bus1.b         = bus0.b;
    assign bus1.x         = bus0.x;
    assign bus1.valid_in  = bus0.valid_in;
    assign bus1.flush     = bus0.flush;
    assign bus1.out_ready = bus0.out_ready;

    param_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(3), .MULT_STAGES(1), .SAT_EN(0))
        u_wrap (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    param_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .VEC_LEN(3), .MULT_STAGES(1), .SAT_EN(1))
        u_sat (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    task automatic check_v(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_elem(input logic signed [DATA_W-1:0] ea, input logic signed [DATA_W-1:0] eb,
                             input logic [DATA_W-1:0] ex);
        int n;
        bus0.a = ea;
        bus0.b = eb;
        bus0.x = ex;
        bus0.valid_in = 1'b1;
        #1;
        n = 0;
        while (!bus0.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", bus0.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_vec(input logic signed [DATA_W-1:0] a0, input logic signed [DATA_W-1:0] a1,
                            input logic signed [DATA_W-1:0] a2, input logic signed [DATA_W-1:0] b0,
                            input logic signed [DATA_W-1:0] b1, input logic signed [DATA_W-1:0] b2,
                            input logic [DATA_W-1:0] xv,
                            input logic [ACC_W-1:0] ew, input logic ow,
                            input logic [ACC_W-1:0] es, input logic os);
        exp_t t;
        t.f = ew; t.ov = ow; q_wrap.push_back(t);
        t.f = es; t.ov = os; q_sat.push_back(t);
        send_elem(a0, b0, xv);
        send_elem(a1, b1, xv);
        send_elem(a2, b2, xv);
        bus0.valid_in = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", bus0.out_valid, n);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && bus0.out_valid && bus0.out_ready) begin
                if (q_wrap.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wrap_extra: unexpected result 0x%04h, required none", bus0.f);
                end else begin
                    e = q_wrap.pop_front();
                    check_v("wrap_f", bus0.f, e.f);
                    check_b("wrap_ovf", bus0.overflow, e.ov);
                end
            end
            if (reset_n && bus1.out_valid && bus1.out_ready) begin
                if (q_sat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sat_extra: unexpected result 0x%04h, required none", bus1.f);
                end else begin
                    e = q_sat.pop_front();
                    check_v("sat_f", bus1.f, e.f);
                    check_b("sat_ovf", bus1.overflow, e.ov);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        bus0.a = '0; bus0.b = '0; bus0.x = '0;
        bus0.valid_in = 1'b0; bus0.flush = 1'b0; bus0.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_v("rst_f", bus0.f, 16'h0000);
        check_b("rst_out_valid", bus0.out_valid, 1'b0);
        check_b("rst_ovf", bus0.overflow, 1'b0);
        check_b("rst_in_ready", bus0.in_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_b("post_rst_in_ready", bus0.in_ready, 1'b1);

        // 10 + 2*5 + 3*6 - 4*7 = 10
        send_vec(8'sd2, 8'sd3, -8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'd10, 16'h000A, 1'b0, 16'h000A, 1'b0);
        wait_out(n);
        check_v("v1_latency", 16'(n), 16'd3);
        @(negedge clk);
        check_b("v1_pulse_drop", bus0.out_valid, 1'b0);

        // 3 x 16384: wraps through 0x8000 to 0xC000, or clamps at 0x7FFF
        send_vec(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'd0, 16'hC000, 1'b1, 16'h7FFF, 1'b1);
        send_vec(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'd1, 16'h0004, 1'b0, 16'h0004, 1'b0);
        repeat (6) @(negedge clk);

        // Backpressure: 7 + 4 + 10 + 18 = 39 held while out_ready=0
        bus0.out_ready = 1'b0;
        send_vec(8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'd7, 16'h0027, 1'b0, 16'h0027, 1'b0);
        wait_out(n);
        bus0.a = -8'sd1; bus0.b = 8'sd1; bus0.x = 8'd100; bus0.valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_b("stall_in_ready", bus0.in_ready, 1'b0);
            check_b("stall_out_valid", bus0.out_valid, 1'b1);
            check_v("stall_f", bus0.f, 16'h0027);
            check_b("stall_ovf", bus0.overflow, 1'b0);
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        // 100 - 1 - 2 - 3 = 94
        send_vec(-8'sd1, -8'sd2, -8'sd3, 8'sd1, 8'sd1, 8'sd1, 8'd100, 16'h005E, 1'b0, 16'h005E, 1'b0);
        repeat (6) @(negedge clk);

        // Partial vector aborted by flush; the rejected element must not count
        send_elem(8'sd9, 8'sd9, 8'd50);
        send_elem(8'sd9, 8'sd9, 8'd50);
        bus0.a = 8'sd5; bus0.b = 8'sd5; bus0.flush = 1'b1;
        #1;
        check_b("flush_in_ready", bus0.in_ready, 1'b0);
        @(negedge clk);
        bus0.flush = 1'b0;
        bus0.valid_in = 1'b0;
        send_vec(8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 8'sd3, 8'd0, 16'h0006, 1'b0, 16'h0006, 1'b0);
        repeat (6) @(negedge clk);

        // Asynchronous reset between edges in the middle of a vector
        send_elem(8'sd7, 8'sd7, 8'd3);
        send_elem(8'sd7, 8'sd7, 8'd3);
        bus0.valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_v("midrst_f", bus0.f, 16'h0000);
        check_v("midrst_sat_f", bus1.f, 16'h0000);
        check_b("midrst_out_valid", bus0.out_valid, 1'b0);
        check_b("midrst_ovf", bus0.overflow, 1'b0);
        check_b("midrst_in_ready", bus0.in_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_b("midrst_release_in_ready", bus0.in_ready, 1'b1);
        // 20 + 15 - 12 - 7 = 16
        send_vec(8'sd5, -8'sd6, 8'sd7, 8'sd3, 8'sd2, -8'sd1, 8'd20, 16'h0010, 1'b0, 16'h0010, 1'b0);
        repeat (8) @(negedge clk);

        check_v("wrap_queue_drained", 16'(q_wrap.size()), 16'd0);
        check_v("sat_queue_drained", 16'(q_sat.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
